// File: rtl/w25qxx_id_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : w25qxx_pkg
//  Purpose  : Opcodes, header length and FSM encoding for the W25Qxx ID
//             responder.
//  Revision : 1.0
// ============================================================================
package w25qxx_pkg;

    localparam logic [7:0] OP_READ_ID    = 8'h90;
    localparam logic [7:0] OP_RELEASE_PD = 8'hAB;
    localparam logic [7:0] OP_JEDEC_ID   = 8'h9F;

    // Index of the last bit in the 24-bit address/dummy phase
    localparam logic [4:0] HDR_LAST_BIT  = 5'd23;
    localparam logic [4:0] CMD_LAST_BIT  = 5'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/w25qxx_id_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : w25qxx_id_responder_if
//  Purpose  : SPI pad bundle between a flash-ID master and the responder.
//  Revision : 1.0
// ============================================================================
interface w25qxx_id_responder_if;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_di;
    logic spi_do;
    logic spi_do_oe;

    modport master (output spi_cs_n, spi_clk, spi_di, input  spi_do, spi_do_oe);
    modport slave  (input  spi_cs_n, spi_clk, spi_di, output spi_do, spi_do_oe);
endinterface
`default_nettype wire

// File: rtl/w25qxx_id_responder_spi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_edge_sync
//  Purpose  : Synchronizes CS/SCK/DI into sys_clk and emits one-cycle edge
//             pulses. SYNC_STAGES must be at least 2.
//  Revision : 1.0
// ============================================================================
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic sys_clk,
    input  wire logic sys_rst_n,
    input  wire logic spi_cs_n,
    input  wire logic spi_clk,
    input  wire logic spi_di,
    output logic      cs_n_sync,
    output logic      di_sync,
    output logic      sck_rise,
    output logic      sck_fall,
    output logic      cs_fall,
    output logic      cs_rise
);

    logic [SYNC_STAGES-1:0] r_cs_pipe;
    logic [SYNC_STAGES-1:0] r_sck_pipe;
    logic [SYNC_STAGES-1:0] r_di_pipe;
    logic                   r_cs_prev;
    logic                   r_sck_prev;

    // CS resets deasserted so no false falling edge appears out of reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cs_pipe  <= '1;
            r_sck_pipe <= '0;
            r_di_pipe  <= '0;
            r_cs_prev  <= 1'b1;
            r_sck_prev <= 1'b0;
        end else begin
            r_cs_pipe  <= {r_cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
            r_sck_pipe <= {r_sck_pipe[SYNC_STAGES-2:0], spi_clk};
            r_di_pipe  <= {r_di_pipe[SYNC_STAGES-2:0], spi_di};
            r_cs_prev  <= r_cs_pipe[SYNC_STAGES-1];
            r_sck_prev <= r_sck_pipe[SYNC_STAGES-1];
        end
    end

    assign cs_n_sync = r_cs_pipe[SYNC_STAGES-1];
    assign di_sync   = r_di_pipe[SYNC_STAGES-1];
    assign sck_rise  =  r_sck_pipe[SYNC_STAGES-1] & ~r_sck_prev;
    assign sck_fall  = ~r_sck_pipe[SYNC_STAGES-1] &  r_sck_prev;
    assign cs_fall   = ~r_cs_pipe[SYNC_STAGES-1]  &  r_cs_prev;
    assign cs_rise   =  r_cs_pipe[SYNC_STAGES-1]  & ~r_cs_prev;

endmodule
`default_nettype wire

// File: rtl/w25qxx_id_responder.sv
`default_nettype none
// ============================================================================
//  Module   : w25qxx_id_responder
//  Purpose  : SPI mode-0 target emulating W25Qxx ID commands (0x90, 0xAB and,
//             with W25QXX_JEDEC_EN defined, 0x9F).
//  Revision : 1.0
// ============================================================================
module w25qxx_id_responder
    import w25qxx_pkg::*;
#(
    parameter logic [7:0] MF_ID       = 8'hEF,
    parameter logic [7:0] DEV_ID      = 8'h14,
    parameter logic [7:0] MEM_TYPE    = 8'h40,
    parameter logic [7:0] CAPACITY    = 8'h15,
    parameter int         SYNC_STAGES = 2
) (
    input  wire logic             sys_clk,
    input  wire logic             sys_rst_n,
    w25qxx_id_responder_if.slave  spi,
    output logic                  cmd_valid,
    output logic [7:0]            cmd_code,
    output logic                  busy
);

    logic w_cs_n_s, w_di_s, w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .spi_cs_n  (spi.spi_cs_n),
        .spi_clk   (spi.spi_clk),
        .spi_di    (spi.spi_di),
        .cs_n_sync (w_cs_n_s),
        .di_sync   (w_di_s),
        .sck_rise  (w_sck_rise),
        .sck_fall  (w_sck_fall),
        .cs_fall   (w_cs_fall),
        .cs_rise   (w_cs_rise)
    );

    state_t     r_state, w_state_next;
    logic [4:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [2:0] r_tx_bit;
    logic [1:0] r_byte_idx;
    logic [7:0] r_cmd_code;
    logic       r_cmd_valid;
    logic       r_spi_do;

    logic [7:0] w_opcode;
    logic [7:0] w_cur_byte;
    logic [1:0] w_idx_next;
    logic       w_op_done;
    logic       w_hdr_done;

    assign w_opcode   = {r_shift, w_di_s};
    assign w_op_done  = (r_state == ST_CMD) && w_sck_rise && (r_bit_cnt == CMD_LAST_BIT);
    assign w_hdr_done = ((r_state == ST_ADDR) || (r_state == ST_DUMMY)) && w_sck_rise
                        && (r_bit_cnt == HDR_LAST_BIT);

    // Byte table per opcode; the 0x9F row is harmless when DATA cannot be reached with it
    always_comb begin
        w_cur_byte = 8'h00;
        w_idx_next = 2'd0;
        case (r_cmd_code)
            OP_READ_ID: begin
                w_cur_byte = r_byte_idx[0] ? DEV_ID : MF_ID;
                w_idx_next = {1'b0, ~r_byte_idx[0]};
            end
            OP_RELEASE_PD: begin
                w_cur_byte = DEV_ID;
            end
            OP_JEDEC_ID: begin
                case (r_byte_idx)
                    2'd0:    w_cur_byte = MF_ID;
                    2'd1:    w_cur_byte = MEM_TYPE;
                    default: w_cur_byte = CAPACITY;
                endcase
                w_idx_next = (r_byte_idx == 2'd2) ? 2'd0 : r_byte_idx + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall) w_state_next = ST_CMD;
                ST_CMD: begin
                    if (w_op_done) begin
                        case (w_opcode)
                            OP_READ_ID:    w_state_next = ST_ADDR;
                            OP_RELEASE_PD: w_state_next = ST_DUMMY;
`ifdef W25QXX_JEDEC_EN
                            OP_JEDEC_ID:   w_state_next = ST_DATA;
`else
                            OP_JEDEC_ID:   w_state_next = ST_IGNORE;
`endif
                            default:       w_state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR, ST_DUMMY: if (w_hdr_done) w_state_next = ST_DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bit_cnt   <= 5'd0;
            r_shift     <= 7'd0;
            r_tx_bit    <= 3'd7;
            r_byte_idx  <= 2'd0;
            r_cmd_code  <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_spi_do    <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_cs_rise) begin
                r_bit_cnt  <= 5'd0;
                r_shift    <= 7'd0;
                r_tx_bit   <= 3'd7;
                r_byte_idx <= 2'd0;
                r_spi_do   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // SCK edges coinciding with the CS fall are dropped here
                        if (w_cs_fall) begin
                            r_bit_cnt  <= 5'd0;
                            r_shift    <= 7'd0;
                            r_tx_bit   <= 3'd7;
                            r_byte_idx <= 2'd0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_shift <= w_opcode[6:0];
                            if (r_bit_cnt == CMD_LAST_BIT) begin
                                r_cmd_code  <= w_opcode;
                                r_cmd_valid <= 1'b1;
                                r_bit_cnt   <= 5'd0;
                                r_tx_bit    <= 3'd7;
                                r_byte_idx  <= 2'd0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR, ST_DUMMY: begin
                        if (w_sck_rise) begin
                            if (r_bit_cnt == HDR_LAST_BIT) begin
                                r_bit_cnt  <= 5'd0;
                                r_tx_bit   <= 3'd7;
                                // addr[0] selects which ID leads the 0x90 sequence
                                r_byte_idx <= ((r_state == ST_ADDR) && w_di_s) ? 2'd1 : 2'd0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sck_fall) begin
                            r_spi_do <= w_cur_byte[r_tx_bit];
                            if (r_tx_bit == 3'd0) begin
                                r_tx_bit   <= 3'd7;
                                r_byte_idx <= w_idx_next;
                            end else begin
                                r_tx_bit <= r_tx_bit - 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi.spi_do    = r_spi_do;
    assign spi.spi_do_oe = (r_state == ST_DATA);
    assign cmd_valid     = r_cmd_valid;
    assign cmd_code      = r_cmd_code;
    assign busy          = ~w_cs_n_s;

endmodule
`default_nettype wire

// File: tb/tb_w25qxx_id_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_w25qxx_id_responder
//  Purpose  : Self-checking bench: SPI mode-0 master, byte-sequence model and
//             a per-cycle output monitor for the W25Qxx ID responder.
//  Revision : 1.0
// ============================================================================
module tb_w25qxx_id_responder;

    localparam logic [7:0] MF   = 8'hEF;
    localparam logic [7:0] DEV  = 8'h14;
    localparam logic [7:0] MEM  = 8'h40;
    localparam logic [7:0] CAP  = 8'h15;
    localparam int         SYNC = 2;
    localparam int         HALF = 6;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       busy;

    w25qxx_id_responder_if spi_if ();

    w25qxx_id_responder #(
        .MF_ID(MF), .DEV_ID(DEV), .MEM_TYPE(MEM), .CAPACITY(CAP), .SYNC_STAGES(SYNC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .spi       (spi_if),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         n_valid   = 0;
    int         cs_stable = 0;
    logic       cs_prev   = 1'b1;
    logic       valid_prev = 1'b0;
    bit         oe_allowed = 1'b0;
    logic [7:0] rx_q [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected output byte k of a read, from the command's documented sequence
    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic a0, input int k);
        case (op)
            8'h90:   return (((k + int'(a0)) % 2) == 0) ? MF : DEV;
            8'hAB:   return DEV;
            8'h9F: begin
                case (k % 3)
                    0:       return MF;
                    1:       return MEM;
                    default: return CAP;
                endcase
            end
            default: return 8'h00;
        endcase
    endfunction

    // Per-cycle monitor
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            cs_stable  = 0;
            valid_prev = 1'b0;
            cs_prev    = spi_if.spi_cs_n;
        end else begin
            if (spi_if.spi_cs_n !== cs_prev) cs_stable = 0;
            else if (cs_stable < 100000)     cs_stable++;
            cs_prev = spi_if.spi_cs_n;
            if (cmd_valid) n_valid++;
            check("cmd_valid_width", valid_prev & cmd_valid, 0);
            valid_prev = cmd_valid;
            if (!oe_allowed) check("oe_outside_data", spi_if.spi_do_oe, 0);
            if (cs_stable >= SYNC + 1) check("busy_vs_cs", busy, !spi_if.spi_cs_n);
            if (spi_if.spi_cs_n && cs_stable >= SYNC + 2) check("do_when_deselected", spi_if.spi_do, 0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Mode 0: DI set while SCK low, DO sampled just before the rising edge
    task automatic spi_bits(input logic [7:0] tx, input int nb, input logic exp_oe,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            spi_if.spi_di = tx[i];
            wait_cyc(HALF);
            rx[i] = spi_if.spi_do;
            check("oe_at_sample", spi_if.spi_do_oe, exp_oe);
            spi_if.spi_clk = 1'b1;
            wait_cyc(HALF);
            spi_if.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_if.spi_cs_n = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_high();
        wait_cyc(HALF);
        spi_if.spi_cs_n = 1'b1;
        wait_cyc(8);
        oe_allowed = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int nhdr,
                           input int nread, input bit data_exp);
        logic [7:0] r;
        int v0;
        v0 = n_valid;
        cs_low();
        if (data_exp && nhdr == 0) oe_allowed = 1'b1;
        spi_bits(op, 8, 1'b0, r);
        for (int h = 0; h < nhdr; h++) begin
            if (data_exp && h == nhdr - 1) oe_allowed = 1'b1;
            spi_bits(addr[23 - 8*h -: 8], 8, 1'b0, r);
        end
        for (int k = 0; k < nread; k++) begin
            spi_bits(8'h00, 8, data_exp, r);
            rx_q[k] = r;
            if (data_exp) check("model_byte", r, model_byte(op, addr[0], k));
        end
        cs_high();
        check("cmd_valid_count", n_valid - v0, 1);
        check("cmd_code", cmd_code, op);
    endtask

    initial begin
        logic [7:0] r;
        int v0;
        spi_if.spi_cs_n = 1'b1;
        spi_if.spi_clk  = 1'b0;
        spi_if.spi_di   = 1'b0;
        wait_cyc(3);
        check("rst_do",        spi_if.spi_do,    0);
        check("rst_oe",        spi_if.spi_do_oe, 0);
        check("rst_cmd_valid", cmd_valid,        0);
        check("rst_cmd_code",  cmd_code,         8'h00);
        check("rst_busy",      busy,             0);
        sys_rst_n = 1'b1;
        wait_cyc(5);

        // 0x90 + 000000h
        run_txn(8'h90, 24'h000000, 3, 2, 1'b1);
        check("t1_byte0", rx_q[0], 8'hEF);
        check("t1_byte1", rx_q[1], 8'h14);

        // 0x90 + 000001h
        run_txn(8'h90, 24'h000001, 3, 4, 1'b1);
        check("t2_byte0", rx_q[0], 8'h14);
        check("t2_byte1", rx_q[1], 8'hEF);
        check("t2_byte2", rx_q[2], 8'h14);
        check("t2_byte3", rx_q[3], 8'hEF);

        // 0xAB, dummy bytes are discarded even with a trailing 1
        run_txn(8'hAB, 24'hFF0155, 3, 2, 1'b1);
        check("t3_byte0", rx_q[0], 8'h14);
        check("t3_byte1", rx_q[1], 8'h14);

        // Unknown opcode
        run_txn(8'h05, 24'h000000, 0, 2, 1'b0);
        check("t4_code", cmd_code, 8'h05);

        // Partial opcode: no pulse, code held
        v0 = n_valid;
        cs_low();
        spi_bits(8'h90, 5, 1'b0, r);
        cs_high();
        check("partial_op_no_valid", n_valid - v0, 0);
        check("partial_op_code_held", cmd_code, 8'h05);

        // Abort after 12 address bits, then a clean read
        v0 = n_valid;
        cs_low();
        spi_bits(8'h90, 8, 1'b0, r);
        spi_bits(8'h00, 8, 1'b0, r);
        spi_bits(8'hFF, 4, 1'b0, r);
        cs_high();
        check("t5_abort_valid", n_valid - v0, 1);
        run_txn(8'h90, 24'h000000, 3, 2, 1'b1);
        check("t5_byte0", rx_q[0], 8'hEF);
        check("t5_byte1", rx_q[1], 8'h14);

        // Reset mid-DATA
        cs_low();
        spi_bits(8'h90, 8, 1'b0, r);
        spi_bits(8'h00, 8, 1'b0, r);
        spi_bits(8'h00, 8, 1'b0, r);
        oe_allowed = 1'b1;
        spi_bits(8'h00, 8, 1'b0, r);
        spi_bits(8'h00, 4, 1'b1, r);
        check("t6_pre_oe", spi_if.spi_do_oe, 1);
        sys_rst_n = 1'b0;
        #1;
        check("t6_oe",        spi_if.spi_do_oe, 0);
        check("t6_busy",      busy,             0);
        check("t6_cmd_code",  cmd_code,         8'h00);
        check("t6_cmd_valid", cmd_valid,        0);
        check("t6_do",        spi_if.spi_do,    0);
        oe_allowed = 1'b0;
        spi_if.spi_cs_n = 1'b1;
        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_cyc(8);
        run_txn(8'h90, 24'h000001, 3, 2, 1'b1);
        check("t6_after_byte0", rx_q[0], 8'h14);

        // 0x9F
`ifdef W25QXX_JEDEC_EN
        run_txn(8'h9F, 24'h000000, 0, 4, 1'b1);
        check("t7_byte0", rx_q[0], 8'hEF);
        check("t7_byte1", rx_q[1], 8'h40);
        check("t7_byte2", rx_q[2], 8'h15);
        check("t7_byte3", rx_q[3], 8'hEF);
`else
        run_txn(8'h9F, 24'h000000, 0, 2, 1'b0);
        check("t7_code", cmd_code, 8'h9F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
